// File: rtl/pci_pkg.sv
// Shared definitions for the PCI memory target: FSM states and command codes.
package pci_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_TURN = 3'd3,
    ST_BUSY = 3'd4
  } state_e;

  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;

endpackage

// File: rtl/pci_addr_counter.sv
// Word index counter for burst transfers: loadable, increments with wrap at DEPTH.
module pci_addr_counter #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [IDX_W-1:0] load_val,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_nxt
);

  logic [IDX_W-1:0] idx_q, idx_d;

  // DEPTH is a power of two, so natural IDX_W-bit overflow gives the wrap.
  always_comb begin
    idx_nxt = idx_q + 1'b1;
    idx_d   = idx_q;
    if (load)     idx_d = load_val;
    else if (inc) idx_d = idx_nxt;
  end

  // Index register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  assign idx = idx_q;

endmodule

// File: rtl/pci_target_mem.sv
// Simple PCI-style memory target: decodes a DEPTH-word window at BASE_ADDR,
// supports read/write bursts with optional initial wait states.
module pci_target_mem
  import pci_pkg::*;
#(
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        DEPTH       = 16,
  parameter logic [DATA_W-1:0]  BASE_ADDR   = '0,
  parameter int unsigned        WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_n,
  input  logic              irdy_n,
  input  logic              cmd,
  input  logic [DATA_W-1:0] ad_in,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              devsel_n,
  output logic              trdy_n,
  output logic [7:0]        xfer_cnt
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam logic [2:0]  WS_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_e            state_q, state_d;
  logic              cmd_q, cmd_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic              devsel_n_q, devsel_n_d;
  logic              trdy_n_q, trdy_n_d;
  logic              ad_oe_q, ad_oe_d;
  logic [DATA_W-1:0] ad_out_q, ad_out_d;
  logic [7:0]        xfer_cnt_q, xfer_cnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] offset;
  logic              hit;
  logic              xfer;
  logic              mem_we;
  logic              idx_load, idx_inc;
  logic [IDX_W-1:0]  idx, idx_nxt;

  pci_addr_counter #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (idx_load),
    .load_val (offset[IDX_W-1:0]),
    .inc      (idx_inc),
    .idx      (idx),
    .idx_nxt  (idx_nxt)
  );

  // Address decode: subtract first, then any bit above the index field means out of window.
  always_comb begin
    offset = ad_in - BASE_ADDR;
    hit    = (ad_in >= BASE_ADDR) && ((offset >> IDX_W) == '0);
    xfer   = (state_q == ST_DATA) && !irdy_n && !trdy_n_q;
    mem_we = rst_n && xfer && (cmd_q == CMD_WRITE);
  end

  // Next-state and registered-output logic; outputs are precomputed one cycle ahead.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    wcnt_d     = wcnt_q;
    devsel_n_d = devsel_n_q;
    trdy_n_d   = trdy_n_q;
    ad_oe_d    = ad_oe_q;
    ad_out_d   = ad_out_q;
    xfer_cnt_d = xfer_cnt_q;
    idx_load   = 1'b0;
    idx_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        devsel_n_d = 1'b1;
        trdy_n_d   = 1'b1;
        ad_oe_d    = 1'b0;
        if (!frame_n) begin
          if (hit) begin
            cmd_d      = cmd;
            idx_load   = 1'b1;
            xfer_cnt_d = '0;
            devsel_n_d = 1'b0;
            ad_oe_d    = (cmd == CMD_READ);
            // Counter loads on this same edge, so read data comes straight from the offset.
            ad_out_d   = mem_q[offset[IDX_W-1:0]];
            if (WAIT_STATES > 0) begin
              state_d  = ST_WAIT;
              wcnt_d   = WS_INIT;
            end else begin
              state_d  = ST_DATA;
              trdy_n_d = 1'b0;
            end
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 3'd0) begin
          state_d  = ST_DATA;
          trdy_n_d = 1'b0;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          idx_inc    = 1'b1;
          xfer_cnt_d = (xfer_cnt_q == 8'hFF) ? xfer_cnt_q : xfer_cnt_q + 8'd1;
          ad_out_d   = mem_q[idx_nxt];
          if (frame_n) begin
            state_d    = ST_TURN;
            devsel_n_d = 1'b1;
            trdy_n_d   = 1'b1;
            ad_oe_d    = 1'b0;
          end
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      ST_BUSY: begin
        if (frame_n && irdy_n) state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        devsel_n_d = 1'b1;
        trdy_n_d   = 1'b1;
        ad_oe_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_WRITE;
      wcnt_q     <= '0;
      devsel_n_q <= 1'b1;
      trdy_n_q   <= 1'b1;
      ad_oe_q    <= 1'b0;
      ad_out_q   <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      wcnt_q     <= wcnt_d;
      devsel_n_q <= devsel_n_d;
      trdy_n_q   <= trdy_n_d;
      ad_oe_q    <= ad_oe_d;
      ad_out_q   <= ad_out_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  // Memory array: synchronous write only, never cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= ad_in;
  end

  assign ad_out   = ad_out_q;
  assign ad_oe    = ad_oe_q;
  assign devsel_n = devsel_n_q;
  assign trdy_n   = trdy_n_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_pci_target_mem.sv
// Directed bench for pci_target_mem: bursts, wrap, stalls, miss, reset abort, wait states.
module tb_pci_target_mem;

  logic        clk = 1'b0;
  logic        rst_n, frame_n, irdy_n, cmd;
  logic [31:0] ad_in;
  logic [31:0] ad_out, ad_out3;
  logic        ad_oe, devsel_n, trdy_n;
  logic        ad_oe3, devsel_n3, trdy_n3;
  logic [7:0]  xfer_cnt, xfer_cnt3;

  logic [31:0] exp_mem [16];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  pci_target_mem #(
    .DATA_W      (32),
    .DEPTH       (16),
    .BASE_ADDR   (32'h10),
    .WAIT_STATES (0)
  ) u0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame_n  (frame_n),
    .irdy_n   (irdy_n),
    .cmd      (cmd),
    .ad_in    (ad_in),
    .ad_out   (ad_out),
    .ad_oe    (ad_oe),
    .devsel_n (devsel_n),
    .trdy_n   (trdy_n),
    .xfer_cnt (xfer_cnt)
  );

  pci_target_mem #(
    .DATA_W      (32),
    .DEPTH       (16),
    .BASE_ADDR   (32'h10),
    .WAIT_STATES (3)
  ) u3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame_n  (frame_n),
    .irdy_n   (irdy_n),
    .cmd      (cmd),
    .ad_in    (ad_in),
    .ad_out   (ad_out3),
    .ad_oe    (ad_oe3),
    .devsel_n (devsel_n3),
    .trdy_n   (trdy_n3),
    .xfer_cnt (xfer_cnt3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    cmd     = 1'b0;
    ad_in   = 32'h0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input int n, input logic [31:0] dbase);
    int idx;
    idx = int'(addr - 32'h10);
    frame_n = 1'b0; cmd = 1'b0; ad_in = addr; irdy_n = 1'b1;
    cyc();
    check("wr_devsel_after_addr", {31'b0, devsel_n}, 32'd0);
    check("wr_trdy_after_addr", {31'b0, trdy_n}, 32'd0);
    check("wr_oe_low", {31'b0, ad_oe}, 32'd0);
    for (int k = 0; k < n; k++) begin
      ad_in = dbase + 32'(k);
      irdy_n = 1'b0;
      frame_n = (k == n - 1);
      cyc();
      exp_mem[(idx + k) % 16] = dbase + 32'(k);
    end
    check("wr_turn_devsel", {31'b0, devsel_n}, 32'd1);
    check("wr_turn_trdy", {31'b0, trdy_n}, 32'd1);
    check("wr_xfer_cnt", {24'b0, xfer_cnt}, 32'(n));
    idle_bus();
    cyc();
    check("wr_idle_devsel", {31'b0, devsel_n}, 32'd1);
  endtask

  task automatic read_burst(input logic [31:0] addr, input int n, input int stall_at);
    int idx;
    idx = int'(addr - 32'h10);
    frame_n = 1'b0; cmd = 1'b1; ad_in = addr; irdy_n = 1'b1;
    cyc();
    check("rd_devsel_after_addr", {31'b0, devsel_n}, 32'd0);
    check("rd_oe_high", {31'b0, ad_oe}, 32'd1);
    for (int k = 0; k < n; k++) begin
      check("rd_data", ad_out, exp_mem[(idx + k) % 16]);
      ad_in = 32'hA5A5_0000 + 32'(k);
      irdy_n = 1'b0;
      frame_n = (k == n - 1);
      cyc();
      if (k == stall_at && k < n - 1) begin
        irdy_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
          cyc();
          check("stall_data", ad_out, exp_mem[(idx + k + 1) % 16]);
          check("stall_cnt", {24'b0, xfer_cnt}, 32'(k + 1));
          check("stall_trdy", {31'b0, trdy_n}, 32'd0);
        end
      end
    end
    check("rd_turn_oe", {31'b0, ad_oe}, 32'd0);
    check("rd_turn_devsel", {31'b0, devsel_n}, 32'd1);
    check("rd_xfer_cnt", {24'b0, xfer_cnt}, 32'(n));
    idle_bus();
    cyc();
    check("rd_idle_devsel", {31'b0, devsel_n}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_bus();
    cyc(); cyc();
    check("rst_devsel", {31'b0, devsel_n}, 32'd1);
    check("rst_trdy", {31'b0, trdy_n}, 32'd1);
    check("rst_oe", {31'b0, ad_oe}, 32'd0);
    check("rst_ad_out", ad_out, 32'd0);
    check("rst_xfer_cnt", {24'b0, xfer_cnt}, 32'd0);
    check("rst_devsel_ws3", {31'b0, devsel_n3}, 32'd1);
    rst_n = 1'b1;
    cyc();

    // Fill every word so later reads have known contents.
    write_burst(32'h10, 16, 32'h0000_1000);
    // Three-word write at index 2.
    write_burst(32'h12, 3, 32'hAAAA_0001);
    read_burst(32'h12, 3, -1);
    // Wrap: write and read across index 15 -> 0.
    write_burst(32'h1F, 3, 32'hD000_0000);
    read_burst(32'h1F, 3, -1);
    // Initiator stall after the first transfer.
    read_burst(32'h12, 3, 0);

    // Miss at 0x40: no DEVSEL, BUSY until frame and irdy both high.
    frame_n = 1'b0; cmd = 1'b0; ad_in = 32'h40; irdy_n = 1'b1;
    cyc();
    check("miss_devsel", {31'b0, devsel_n}, 32'd1);
    check("miss_trdy", {31'b0, trdy_n}, 32'd1);
    check("miss_oe", {31'b0, ad_oe}, 32'd0);
    ad_in = 32'hDEAD_BEEF; irdy_n = 1'b0; frame_n = 1'b1;
    cyc();
    check("miss_devsel_data", {31'b0, devsel_n}, 32'd1);
    idle_bus();
    cyc();
    read_burst(32'h10, 4, -1);

    // Reset during the second data phase of a write.
    frame_n = 1'b0; cmd = 1'b0; ad_in = 32'h15; irdy_n = 1'b1;
    cyc();
    ad_in = 32'hE000_0001; irdy_n = 1'b0;
    cyc();
    exp_mem[5] = 32'hE000_0001;
    ad_in = 32'hE000_0002; rst_n = 1'b0;
    cyc();
    check("abort_devsel", {31'b0, devsel_n}, 32'd1);
    check("abort_trdy", {31'b0, trdy_n}, 32'd1);
    check("abort_oe", {31'b0, ad_oe}, 32'd0);
    check("abort_ad_out", ad_out, 32'd0);
    check("abort_xfer_cnt", {24'b0, xfer_cnt}, 32'd0);
    rst_n = 1'b1;
    idle_bus();
    cyc();
    read_burst(32'h15, 2, -1);

    // Wait-state instance: clean reset, then single-word write at index 8.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    frame_n = 1'b0; cmd = 1'b0; ad_in = 32'h18; irdy_n = 1'b1;
    cyc();
    check("ws_devsel", {31'b0, devsel_n3}, 32'd0);
    check("ws_trdy_c0", {31'b0, trdy_n3}, 32'd1);
    ad_in = 32'hF00D_0008; irdy_n = 1'b0; frame_n = 1'b1;
    cyc();
    check("ws_trdy_c1", {31'b0, trdy_n3}, 32'd1);
    check("ws_cnt_c1", {24'b0, xfer_cnt3}, 32'd0);
    cyc();
    check("ws_trdy_c2", {31'b0, trdy_n3}, 32'd1);
    check("ws_cnt_c2", {24'b0, xfer_cnt3}, 32'd0);
    cyc();
    check("ws_trdy_c3", {31'b0, trdy_n3}, 32'd0);
    check("ws_cnt_c3", {24'b0, xfer_cnt3}, 32'd0);
    cyc();
    check("ws_cnt_done", {24'b0, xfer_cnt3}, 32'd1);
    check("ws_turn_devsel", {31'b0, devsel_n3}, 32'd1);
    idle_bus();
    cyc();
    // Read it back through the wait-state instance.
    frame_n = 1'b0; cmd = 1'b1; ad_in = 32'h18; irdy_n = 1'b1;
    cyc();
    check("ws_rd_oe", {31'b0, ad_oe3}, 32'd1);
    check("ws_rd_data", ad_out3, 32'hF00D_0008);
    irdy_n = 1'b0; frame_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check("ws_rd_end_oe", {31'b0, ad_oe3}, 32'd0);
    check("ws_rd_end_devsel", {31'b0, devsel_n3}, 32'd1);
    check("ws_rd_end_cnt", {24'b0, xfer_cnt3}, 32'd1);
    idle_bus();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pci_target_mem.md
PCI_TARGET_MEM -- requirements
Module: pci_target_mem

Interface
REQ-001 Parameter DATA_W, default 32, width of address/data bus and memory word.
REQ-002 Parameter DEPTH, default 16, number of memory words; power of two, 2..256.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, base of the decoded window of DEPTH words.
REQ-004 Parameter WAIT_STATES, default 0, range 0..7; TRDY latency after DEVSEL on the first data phase only.
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 frame_n  input  1  initiator FRAME#, active-low.
REQ-008 irdy_n  input  1  initiator ready, active-low.
REQ-009 cmd  input  1  sampled in address phase: 1 = read, 0 = write.
REQ-010 ad_in  input  DATA_W  bus value: address in address phase, write data in data phases.
REQ-011 ad_out  output  DATA_W  read data.
REQ-012 ad_oe  output  1  1 = target drives ad_out onto the bus.
REQ-013 devsel_n  output  1  device select, active-low.
REQ-014 trdy_n  output  1  target ready, active-low.
REQ-015 xfer_cnt  output  8  count of completed data phases in the current/last transaction.

Function
REQ-016 All outputs SHALL be registered; inputs sampled at posedge clk.
REQ-017 States SHALL be IDLE, WAIT, DATA, TURN, BUSY.
REQ-018 IDLE: frame_n=0 sampled -> address phase; hit if BASE_ADDR <= ad_in < BASE_ADDR+DEPTH (word addresses).
REQ-019 Hit: capture cmd and word index ad_in-BASE_ADDR, clear xfer_cnt; next state WAIT if WAIT_STATES>0, else DATA.
REQ-020 Miss: next state BUSY; devsel_n, trdy_n, ad_oe stay deasserted.
REQ-021 devsel_n SHALL be 0 in the cycle after a hitting address phase and stay 0 through DATA.
REQ-022 WAIT SHALL last exactly WAIT_STATES cycles with trdy_n=1, then go to DATA.
REQ-023 DATA: trdy_n=0; a transfer occurs at a posedge where irdy_n=0 and trdy_n=0.
REQ-024 irdy_n=1 in DATA: insert initiator wait; hold index, data and outputs.
REQ-025 Write transfer: mem[index] <= ad_in.
REQ-026 Read: ad_oe=1 from the first cycle after the address phase until leaving DATA; ad_out = mem[index]; after a transfer ad_out shows mem[index+1] in the next cycle.
REQ-027 Each transfer SHALL increment the index modulo DEPTH (DEPTH-1 wraps to 0) and xfer_cnt saturating at 255.
REQ-028 Transfer with frame_n=1 is the last phase -> TURN; otherwise remain in DATA with zero wait states.
REQ-029 TURN: devsel_n=1, trdy_n=1, ad_oe=0 for one cycle, then IDLE; a frame_n=0 seen in TURN is not decoded.
REQ-030 BUSY: return to IDLE once frame_n=1 and irdy_n=1 are sampled together.
REQ-031 Memory contents SHALL be unaffected by read transactions and by misses.

Reset
REQ-032 rst_n=0 at posedge: state IDLE, devsel_n=1, trdy_n=1, ad_oe=0, ad_out=0, xfer_cnt=0, index=0, overriding any activity.
REQ-033 Reset mid-transaction SHALL abort it; no write occurs in the reset cycle; memory contents are not cleared.

Structure
REQ-034 Shared package pci_pkg: state encoding, CMD_READ=1/CMD_WRITE=0 constants.
REQ-035 Index counter SHALL be sub-module pci_addr_counter (parameter DEPTH; load, increment-with-wrap, synchronous active-low reset).
REQ-036 Memory SHALL be an inferred DEPTH x DATA_W array, synchronous write.

Verification
REQ-037 Write burst: BASE=0x10, addr 0x12, data A,B,C, WAIT_STATES=0 -> devsel_n low one cycle after address, mem[2..4]=A,B,C, xfer_cnt=3, TURN then IDLE.
REQ-038 Read burst with wrap: DEPTH=16, start index 15, 3 phases -> ad_out = mem[15], mem[0], mem[1]; ad_oe low in TURN.
REQ-039 WAIT_STATES=3 -> trdy_n goes low exactly 3 cycles after devsel_n; no transfer before it.
REQ-040 Initiator stall: irdy_n high 2 cycles mid-burst -> index and ad_out held, xfer_cnt unchanged.
REQ-041 Miss at address 0x40 -> devsel_n never asserts; mem unchanged; IDLE after frame_n=1, irdy_n=1.
REQ-042 rst_n low during second data phase of a write -> outputs at reset values next cycle; first word written, second not.
